// File: rtl/accel_pkg.sv
// Shared types and constants for the fully-connected layer sequencer:
// FSM state encoding, descriptor word order and the captured descriptor record.
package accel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONFIG,
    FETCH,
    WAIT_DVAL,
    MAC,
    ACCUM,
    WRITE
  } layer_state_e;

  localparam int DESC_WORDS = 5;

  localparam logic [2:0] DESC_IN_BASE  = 3'd0;
  localparam logic [2:0] DESC_WT_BASE  = 3'd1;
  localparam logic [2:0] DESC_OUT_BASE = 3'd2;
  localparam logic [2:0] DESC_N_IN     = 3'd3;
  localparam logic [2:0] DESC_N_OUT    = 3'd4;

  // Fields are stored zero-extended to this width; ADDR_W and CNT_W must not exceed it.
  localparam int DESC_FIELD_W = 32;

  typedef struct packed {
    logic [DESC_FIELD_W-1:0] in_base;
    logic [DESC_FIELD_W-1:0] wt_base;
    logic [DESC_FIELD_W-1:0] out_base;
    logic [DESC_FIELD_W-1:0] n_in;
    logic [DESC_FIELD_W-1:0] n_out;
  } layer_desc_t;

endpackage

// File: rtl/layer_sequencer_lane_mask.sv
// lane_mask_gen: valid-lane mask for one input chunk. Every lane is valid except
// on the last chunk of a row whose input count leaves a remainder r, where only lanes 0..r-1 are.
module lane_mask_gen
  import accel_pkg::*;
#(
  parameter int NUM_PE = 16,
  parameter int CNT_W  = 10
) (
  input  logic [CNT_W-1:0]  n_in_i,
  input  logic              last_chunk_i,
  output logic [NUM_PE-1:0] lane_mask_o
);

  localparam int LOG2_PE = $clog2(NUM_PE);

  logic [LOG2_PE-1:0] rem;
  assign rem = n_in_i[LOG2_PE-1:0];

  generate
    for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_lane
      assign lane_mask_o[gi] = !last_chunk_i || (rem == '0) || (LOG2_PE'(gi) < rem);
    end
  endgenerate

endmodule

// File: rtl/layer_sequencer.sv
// Fully-connected layer sequencer: captures a five-word descriptor, then fetches, MACs
// and writes one output neuron per row. Define LAYER_SEQ_PERF_EN for the perf_stall/perf_layers counters.
module layer_sequencer
  import accel_pkg::*;
#(
  parameter int NUM_PE  = 16,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int CNT_W   = 10,
  parameter int ADD_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              busrdwr,
  input  logic [DATA_W-1:0] databus,
  input  logic              dval,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] in_addr,
  output logic [ADDR_W-1:0] wt_addr,
  output logic [ADDR_W-1:0] out_addr,
  output logic [NUM_PE-1:0] lane_mask,
  output logic              mac_en,
  output logic              acc_clear,
  output logic              wr_bram,
  output logic              neuron_done,
  output logic              layer_done,
  output logic              busy,
  output logic              cfg_err
`ifdef LAYER_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_stall,
  output logic [15:0]       perf_layers
`endif
);

  localparam int LOG2_PE = $clog2(NUM_PE);
  // ACCUM always lasts at least one cycle; ADD_LAT of 0 behaves as 1.
  localparam int WAIT_W  = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (ADD_LAT > 1) ? WAIT_W'(ADD_LAT - 1) : '0;

  layer_state_e      state_q;
  layer_desc_t       desc_q;
  logic [2:0]        word_q;
  logic [CNT_W-1:0]  chunk_q;
  logic [CNT_W-1:0]  neuron_q;
  logic              last_chunk_q;
  logic [WAIT_W-1:0] wait_q;
  logic [ADDR_W-1:0] in_addr_q;
  logic [ADDR_W-1:0] wt_addr_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic              fetch_req_q;
  logic              mac_en_q;
  logic              acc_clear_q;
  logic              wr_bram_q;
  logic              layer_done_q;
  logic              busy_q;
  logic              cfg_err_q;

  logic [CNT_W-1:0]  n_in_w;
  logic [CNT_W-1:0]  n_out_w;
  logic [CNT_W-1:0]  n_out_bus;
  logic [ADDR_W-1:0] in_base_w;
  logic [CNT_W:0]    chunks_w;
  logic              next_is_last;
  logic              last_neuron;

  assign n_in_w    = desc_q.n_in[CNT_W-1:0];
  assign n_out_w   = desc_q.n_out[CNT_W-1:0];
  assign n_out_bus = databus[CNT_W-1:0];
  assign in_base_w = desc_q.in_base[ADDR_W-1:0];

  // ceil(n_in / NUM_PE), one extra bit so n_in near full scale cannot overflow.
  assign chunks_w     = ({1'b0, n_in_w} + (CNT_W+1)'(NUM_PE - 1)) >> LOG2_PE;
  assign next_is_last = (({1'b0, chunk_q} + (CNT_W+1)'(2)) == chunks_w);
  assign last_neuron  = (neuron_q == (n_out_w - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      desc_q       <= '0;
      word_q       <= '0;
      chunk_q      <= '0;
      neuron_q     <= '0;
      last_chunk_q <= 1'b0;
      wait_q       <= '0;
      in_addr_q    <= '0;
      wt_addr_q    <= '0;
      out_addr_q   <= '0;
      fetch_req_q  <= 1'b0;
      mac_en_q     <= 1'b0;
      acc_clear_q  <= 1'b0;
      wr_bram_q    <= 1'b0;
      layer_done_q <= 1'b0;
      busy_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      fetch_req_q  <= 1'b0;
      mac_en_q     <= 1'b0;
      acc_clear_q  <= 1'b0;
      wr_bram_q    <= 1'b0;
      layer_done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q   <= CONFIG;
            busy_q    <= 1'b1;
            cfg_err_q <= 1'b0;
            word_q    <= '0;
          end
        end

        CONFIG: begin
          if (busrdwr) begin
            word_q <= word_q + 3'd1;
            case (word_q)
              DESC_IN_BASE:  desc_q.in_base  <= DESC_FIELD_W'(databus[ADDR_W-1:0]);
              DESC_WT_BASE:  desc_q.wt_base  <= DESC_FIELD_W'(databus[ADDR_W-1:0]);
              DESC_OUT_BASE: desc_q.out_base <= DESC_FIELD_W'(databus[ADDR_W-1:0]);
              DESC_N_IN:     desc_q.n_in     <= DESC_FIELD_W'(databus[CNT_W-1:0]);
              DESC_N_OUT: begin
                desc_q.n_out <= DESC_FIELD_W'(n_out_bus);
                if ((n_in_w == '0) || (n_out_bus == '0)) begin
                  cfg_err_q <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= IDLE;
                end else begin
                  in_addr_q    <= in_base_w;
                  wt_addr_q    <= desc_q.wt_base[ADDR_W-1:0];
                  out_addr_q   <= desc_q.out_base[ADDR_W-1:0];
                  chunk_q      <= '0;
                  neuron_q     <= '0;
                  last_chunk_q <= (chunks_w == (CNT_W+1)'(1));
                  fetch_req_q  <= 1'b1;
                  state_q      <= FETCH;
                end
              end
              default: ;
            endcase
          end
        end

        // A dval coinciding with the request itself is dropped: SRAM latency is at least one cycle.
        FETCH: state_q <= WAIT_DVAL;

        WAIT_DVAL: begin
          if (dval) begin
            mac_en_q    <= 1'b1;
            acc_clear_q <= (chunk_q == '0);
            state_q     <= MAC;
          end
        end

        MAC: begin
          in_addr_q <= in_addr_q + ADDR_W'(NUM_PE);
          wt_addr_q <= wt_addr_q + ADDR_W'(NUM_PE);
          wait_q    <= '0;
          state_q   <= ACCUM;
        end

        ACCUM: begin
          if (wait_q == WAIT_LAST) begin
            if (last_chunk_q) begin
              wr_bram_q <= 1'b1;
              state_q   <= WRITE;
            end else begin
              chunk_q      <= chunk_q + CNT_W'(1);
              last_chunk_q <= next_is_last;
              fetch_req_q  <= 1'b1;
              state_q      <= FETCH;
            end
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end

        // wt_addr is not rewound: weight rows are contiguous, so it already points at the next row.
        WRITE: begin
          out_addr_q <= out_addr_q + ADDR_W'(1);
          in_addr_q  <= in_base_w;
          chunk_q    <= '0;
          neuron_q   <= neuron_q + CNT_W'(1);
          if (last_neuron) begin
            last_chunk_q <= 1'b0;
            layer_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end else begin
            last_chunk_q <= (chunks_w == (CNT_W+1)'(1));
            fetch_req_q  <= 1'b1;
            state_q      <= FETCH;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  lane_mask_gen #(
    .NUM_PE (NUM_PE),
    .CNT_W  (CNT_W)
  ) u_lane_mask (
    .n_in_i       (n_in_w),
    .last_chunk_i (last_chunk_q),
    .lane_mask_o  (lane_mask)
  );

  assign fetch_req   = fetch_req_q;
  assign in_addr     = in_addr_q;
  assign wt_addr     = wt_addr_q;
  assign out_addr    = out_addr_q;
  assign mac_en      = mac_en_q;
  assign acc_clear   = acc_clear_q;
  assign wr_bram     = wr_bram_q;
  assign neuron_done = wr_bram_q;
  assign layer_done  = layer_done_q;
  assign busy        = busy_q;
  assign cfg_err     = cfg_err_q;

  // Upper descriptor/databus bits beyond ADDR_W/CNT_W are carried but never consumed.
  logic unused_desc_bits;
  assign unused_desc_bits = ^{desc_q, databus};

`ifdef LAYER_SEQ_PERF_EN
  logic [31:0] perf_stall_q;
  logic [15:0] perf_layers_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_q  <= '0;
      perf_layers_q <= '0;
    end else begin
      if ((state_q == WAIT_DVAL) && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (layer_done_q && (perf_layers_q != '1)) begin
        perf_layers_q <= perf_layers_q + 16'd1;
      end
    end
  end

  assign perf_stall  = perf_stall_q;
  assign perf_layers = perf_layers_q;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: the driver pushes hand-computed events
// (fetch, MAC, write, done, with cycle stamps) and a negedge monitor pops and compares them.
module tb_layer_sequencer;

  localparam int NUM_PE  = 16;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int CNT_W   = 10;
  localparam int ADD_LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        enable;
  logic        busrdwr;
  logic [15:0] databus;
  logic        dval;
  logic        resp_dval;
  logic        spur_dval;
  logic        fetch_req;
  logic [15:0] in_addr;
  logic [15:0] wt_addr;
  logic [15:0] out_addr;
  logic [15:0] lane_mask;
  logic        mac_en;
  logic        acc_clear;
  logic        wr_bram;
  logic        neuron_done;
  logic        layer_done;
  logic        busy;
  logic        cfg_err;
`ifdef LAYER_SEQ_PERF_EN
  logic [31:0] perf_stall;
  logic [15:0] perf_layers;
`endif

  assign dval = resp_dval | spur_dval;

  layer_sequencer #(
    .NUM_PE  (NUM_PE),
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .CNT_W   (CNT_W),
    .ADD_LAT (ADD_LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .busrdwr     (busrdwr),
    .databus     (databus),
    .dval        (dval),
    .fetch_req   (fetch_req),
    .in_addr     (in_addr),
    .wt_addr     (wt_addr),
    .out_addr    (out_addr),
    .lane_mask   (lane_mask),
    .mac_en      (mac_en),
    .acc_clear   (acc_clear),
    .wr_bram     (wr_bram),
    .neuron_done (neuron_done),
    .layer_done  (layer_done),
    .busy        (busy),
    .cfg_err     (cfg_err)
`ifdef LAYER_SEQ_PERF_EN
    ,
    .perf_stall  (perf_stall),
    .perf_layers (perf_layers)
`endif
  );

  typedef enum int {EV_FETCH, EV_MAC, EV_WRITE, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] m;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int got, int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, got, got, req, req);
    end else begin
      $display("ok   %s: %0d (0x%0h)", name, got, got);
    end
  endfunction

  function automatic void chk_vec(string name, logic [71:0] got, logic [71:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endfunction

  function automatic void observe(ev_kind_e k, logic [15:0] a, logic [15:0] b, logic [15:0] m);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s cycle %0d: got a=%h b=%h mask=%h required no event", k.name(), cyc, a, b, m);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.a !== a || e.b !== b || e.m !== m || (e.cyc >= 0 && e.cyc != cyc)) begin
        errors++;
        $display("FAIL event_%s cycle %0d: got a=%h b=%h mask=%h required %s a=%h b=%h mask=%h cycle %0d",
                 k.name(), cyc, a, b, m, e.kind.name(), e.a, e.b, e.m, e.cyc);
      end else begin
        $display("ok   %s cycle %0d a=%h b=%h mask=%h", k.name(), cyc, a, b, m);
      end
    end
  endfunction

  // Monitor: one comparison per DUT-presented event.
  always @(negedge clk) begin
    if (fetch_req) observe(EV_FETCH, in_addr, wt_addr, lane_mask);
    if (mac_en || acc_clear) observe(EV_MAC, {14'b0, mac_en, acc_clear}, 16'h0, lane_mask);
    if (wr_bram || neuron_done) observe(EV_WRITE, out_addr, {14'b0, wr_bram, neuron_done}, 16'h0);
    if (layer_done) observe(EV_DONE, 16'h0, 16'h0, 16'h0);
  end

  // SRAM model: dval three cycles after each fetch_req.
  initial begin
    resp_dval = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (fetch_req) begin
        repeat (3) @(posedge clk);
        #1 resp_dval = 1'b1;
        @(posedge clk);
        #1 resp_dval = 1'b0;
      end
    end
  end

  function automatic void push(ev_kind_e k, logic [15:0] a, logic [15:0] b, logic [15:0] m, int c);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.m = m; e.cyc = c;
    exp_q.push_back(e);
  endfunction

  // Two chunks x two neurons with dval latency 3 and ADD_LAT 4: 9 cycles per chunk, +1 per WRITE.
  function automatic void push_2x2(logic [15:0] ib, logic [15:0] wb, logic [15:0] ob,
                                   logic [15:0] ml, int f, int upto);
    ev_t t[11];
    t[0]  = '{EV_FETCH, ib,          wb,          16'hFFFF, f};
    t[1]  = '{EV_MAC,   16'h3,       16'h0,       16'hFFFF, f + 4};
    t[2]  = '{EV_FETCH, ib + 16'h10, wb + 16'h10, ml,       f + 9};
    t[3]  = '{EV_MAC,   16'h2,       16'h0,       ml,       f + 13};
    t[4]  = '{EV_WRITE, ob,          16'h3,       16'h0,    f + 18};
    t[5]  = '{EV_FETCH, ib,          wb + 16'h20, 16'hFFFF, f + 19};
    t[6]  = '{EV_MAC,   16'h3,       16'h0,       16'hFFFF, f + 23};
    t[7]  = '{EV_FETCH, ib + 16'h10, wb + 16'h30, ml,       f + 28};
    t[8]  = '{EV_MAC,   16'h2,       16'h0,       ml,       f + 32};
    t[9]  = '{EV_WRITE, ob + 16'h1,  16'h3,       16'h0,    f + 37};
    t[10] = '{EV_DONE,  16'h0,       16'h0,       16'h0,    f + 38};
    for (int i = 0; i < upto; i++) exp_q.push_back(t[i]);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start();
    enable = 1'b1; tick(); enable = 1'b0;
  endtask

  task automatic send(logic [15:0] w);
    busrdwr = 1'b1; databus = w; tick(); busrdwr = 1'b0; databus = 16'h0;
  endtask

  task automatic wait_idle(string name, int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending events after %0d cycles required 0", name, exp_q.size(), n);
    end else begin
      $display("ok   %s complete after %0d cycles", name, n);
    end
  endtask

  function automatic logic [71:0] out_vec();
    return {fetch_req, mac_en, acc_clear, wr_bram, neuron_done, layer_done, busy, cfg_err,
            lane_mask, in_addr, wt_addr, out_addr};
  endfunction

  localparam logic [71:0] RESET_VEC = {8'h00, 16'hFFFF, 48'h0};

  initial begin
    int f;
    rst = 1'b0; enable = 1'b0; busrdwr = 1'b0; databus = 16'h0; spur_dval = 1'b0;
    repeat (3) tick();
    chk_vec("reset_state", out_vec(), RESET_VEC);
    rst = 1'b1;
    tick();

    // Scenario 1: 32 inputs, 2 neurons.
    start();
    send(16'h0100); send(16'h0800); send(16'h0040); send(16'd32);
    f = cyc + 1;
    push_2x2(16'h0100, 16'h0800, 16'h0040, 16'hFFFF, f, 11);
    send(16'd2);
    chk("busy_running", int'(busy), 1);
    wait_idle("layer32", 300);
    chk("busy_after_layer", int'(busy), 0);
`ifdef LAYER_SEQ_PERF_EN
    chk("perf_stall", int'(perf_stall), 12);
    chk("perf_layers", int'(perf_layers), 1);
`endif

    // Scenario 2: 20 inputs (partial last chunk) with spurious dval/enable/busrdwr.
    spur_dval = 1'b1; busrdwr = 1'b1; databus = 16'hDEAD; tick();
    spur_dval = 1'b0; busrdwr = 1'b0; databus = 16'h0; tick();
    chk("idle_spurious_busy", int'(busy), 0);
    start();
    send(16'h0100); send(16'h0900); send(16'h0050); send(16'd20);
    f = cyc + 1;
    push_2x2(16'h0100, 16'h0900, 16'h0050, 16'h000F, f, 11);
    send(16'd2);
    repeat (6) tick();
    spur_dval = 1'b1; enable = 1'b1; busrdwr = 1'b1; databus = 16'hBEEF; tick();
    spur_dval = 1'b0; enable = 1'b0; busrdwr = 1'b0; databus = 16'h0;
    wait_idle("layer20", 300);

    // Scenario 3: illegal descriptors, then a single-chunk single-neuron layer.
    start();
    send(16'h0010); send(16'h0020); send(16'h0030); send(16'd0);
    chk("busy_before_word4", int'(busy), 1);
    send(16'd3);
    chk("cfg_err_n_in0", int'(cfg_err), 1);
    chk("busy_drop_n_in0", int'(busy), 0);
    repeat (3) tick();
    chk("cfg_err_sticky", int'(cfg_err), 1);
    start();
    chk("cfg_err_cleared", int'(cfg_err), 0);
    send(16'h0010); send(16'h0020); send(16'h0030); send(16'd5);
    send(16'd0);
    chk("cfg_err_n_out0", int'(cfg_err), 1);
    chk("busy_drop_n_out0", int'(busy), 0);
    start();
    send(16'h0200); send(16'h0A00); send(16'h0070); send(16'd5);
    f = cyc + 1;
    push(EV_FETCH, 16'h0200, 16'h0A00, 16'h001F, f);
    push(EV_MAC,   16'h3,    16'h0,    16'h001F, f + 4);
    push(EV_WRITE, 16'h0070, 16'h3,    16'h0,    f + 9);
    push(EV_DONE,  16'h0,    16'h0,    16'h0,    f + 10);
    send(16'd1);
    wait_idle("layer5", 100);
    chk("cfg_err_after_good", int'(cfg_err), 0);

    // Scenario 4: reset during ACCUM of neuron 1.
    start();
    send(16'h0100); send(16'h0800); send(16'h0060); send(16'd32);
    f = cyc + 1;
    push_2x2(16'h0100, 16'h0800, 16'h0060, 16'hFFFF, f, 7);
    send(16'd2);
    repeat (25) tick();
    rst = 1'b0;
    tick();
    chk_vec("abort_reset_state", out_vec(), RESET_VEC);
    rst = 1'b1;
    repeat (60) tick();
    chk("abort_pending_events", exp_q.size(), 0);
    chk("abort_busy", int'(busy), 0);
`ifdef LAYER_SEQ_PERF_EN
    chk("perf_stall_reset", int'(perf_stall), 0);
    chk("perf_layers_reset", int'(perf_layers), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Parametrised successor to the accelerator control FSM. It sequences one fully-connected layer on a NUM_PE-wide PE array. It captures a five-word layer descriptor from the CPU data bus, then issues one SRAM fetch request per input chunk and drives the PE multiply/accumulate strobes. It writes one output neuron per completed dot product. Unlike the previous generation, it handles input counts that are not a multiple of NUM_PE through a lane mask, models a configurable adder-tree latency, and flags illegal descriptors.

## Interface
- NUM_PE, 16: parallel multipliers; power of two, 2..64
- DATA_W, 16: databus and descriptor word width
- ADDR_W, 16: address width; must be ≤ DATA_W
- CNT_W, 10: width of the neuron counters
- ADD_LAT, 4: cycles the adder tree needs after the MAC strobe
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-low
- enable  in  1  starts a layer; sampled in IDLE only
- busrdwr  in  1  descriptor word strobe
- databus  in  DATA_W  descriptor word
- dval  in  1  SRAM fetch data valid (one-cycle pulse)
- fetch_req  out  1  one-cycle request for NUM_PE words at in_addr/wt_addr
- in_addr  out  ADDR_W  current input-activation chunk address
- wt_addr  out  ADDR_W  current weight chunk address
- out_addr  out  ADDR_W  output BRAM write address
- lane_mask  out  NUM_PE  valid lanes for the current chunk
- mac_en  out  1  PE multiply/accumulate strobe
- acc_clear  out  1  clear the accumulator; coincides with the first mac_en of each neuron
- wr_bram  out  1  write the accumulator to out_addr
- neuron_done  out  1  one-cycle pulse, same cycle as wr_bram
- layer_done  out  1  one-cycle pulse after the last neuron
- busy  out  1  high in any state other than IDLE
- cfg_err  out  1  sticky illegal-descriptor flag

## Operation
- States: IDLE, CONFIG, FETCH, WAIT_DVAL, MAC, ACCUM, WRITE.
- IDLE:
  - On enable, go to CONFIG, clear cfg_err and the word counter.
  - busrdwr and dval are ignored.
- CONFIG: each busrdwr captures databus in this order:
  - word 0: in_base
  - word 1: wt_base
  - word 2: out_base
  - word 3: n_in
  - word 4: n_out
- Address fields take databus[ADDR_W-1:0]. Counts take databus[CNT_W-1:0].
- After word 4:
  - If n_in == 0 or n_out == 0, set cfg_err and return to IDLE. layer_done is not pulsed.
  - Otherwise load in_addr = in_base, wt_addr = wt_base, out_addr = out_base, chunk = 0, neuron = 0, and go to FETCH.
- Chunk count is chunks = ceil(n_in / NUM_PE).
- lane_mask is all ones except on the last chunk when n_in mod NUM_PE = r ≠ 0. In that case the mask is the low r bits.
- FETCH: assert fetch_req for one cycle, then go to WAIT_DVAL.
- WAIT_DVAL: hold until dval, then go to MAC. dval pulses seen in any other state are dropped.
- MAC (one cycle):
  - mac_en = 1; acc_clear = 1 when chunk == 0.
  - in_addr += NUM_PE and wt_addr += NUM_PE.
  - Go to ACCUM.
- ACCUM: wait exactly ADD_LAT cycles. Then:
  - if this is not the last chunk: chunk++ and go to FETCH;
  - if this is the last chunk: go to WRITE.
- WRITE (one cycle):
  - wr_bram = neuron_done = 1 using the current out_addr.
  - Next cycle: out_addr++, in_addr = in_base, chunk = 0, neuron++.
  - wt_addr keeps advancing; weights are row-contiguous with a stride of chunks·NUM_PE.
  - If the neuron just written was n_out−1, pulse layer_done and go to IDLE; otherwise go to FETCH.
- Address arithmetic wraps modulo 2^ADDR_W and is not flagged.

## Timing
- Reset values:
  - all outputs 0, except lane_mask = all ones;
  - state IDLE; counters and addresses 0.
- Reset asserted mid-layer aborts at the next edge. There is no write and no layer_done.
- The first fetch_req occurs 1 cycle after the word-4 strobe.
- mac_en occurs 1 cycle after the dval cycle.
- Per-chunk cost is 1 (FETCH) + wait + 1 (MAC) + ADD_LAT cycles. WRITE adds 1 cycle per neuron.
- enable while busy is ignored. busrdwr outside CONFIG is ignored.
- dval in the same cycle as the fetch_req (FETCH state) is dropped; the SRAM interface guarantees a latency of at least 1.

## Configuration
- LAYER_SEQ_PERF_EN defined:
  - Adds output perf_stall (32 bits) counting cycles spent in WAIT_DVAL.
  - Adds output perf_layers (16 bits) counting layer_done pulses.
  - Both clear on rst, saturate at their maximum, and are not cleared by enable.
- LAYER_SEQ_PERF_EN undefined: neither port nor counter exists.

## Structure
- Package accel_pkg holds:
  - the state enum layer_state_e;
  - the descriptor word index constants (DESC_IN_BASE .. DESC_N_OUT);
  - typedef layer_desc_t, a struct holding the five fields.
- One sub-module, lane_mask_gen (NUM_PE, CNT_W): a combinational mask from n_in and the last-chunk flag.
- The FSM, counters and address registers stay in layer_sequencer.

## Test plan
- NUM_PE=16, ADD_LAT=4, descriptor (0x100, 0x800, 0x40, 32, 2), dval 3 cycles after each fetch_req -> 4 fetch_reqs; wt_addr 0x800,0x810,0x820,0x830; wr_bram at out_addr 0x40 then 0x41; one layer_done.
- n_in=20 -> 2 chunks per neuron; the second chunk has lane_mask 0x000F; in_addr returns to 0x100 after each WRITE.
- n_in=0 or n_out=0 -> cfg_err=1, no fetch_req, busy drops 1 cycle after word 4; the next enable clears cfg_err.
- rst low during ACCUM of neuron 1 -> next cycle all outputs 0 and IDLE; no wr_bram or layer_done.
- Spurious dval in IDLE and in ACCUM, and enable pulses while busy -> no change to fetch count, addresses or sequence.
- With LAYER_SEQ_PERF_EN, first scenario -> perf_stall = 12 (4 fetches × 3 wait cycles), perf_layers = 1.
